// File: rtl/lite_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : lite_fetch_pkg
//  Description : Shared state encoding, opcode-length bit and helper for the
//                instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package lite_fetch_pkg;

   // Fetch FSM states; the 3-bit encoding is relied on by the fetch unit.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE_OP  = 3'd1,
      WAIT_OP   = 3'd2,
      ISSUE_ARG = 3'd3,
      WAIT_ARG  = 3'd4,
      HOLD      = 3'd5,
      SQUASH    = 3'd6
   } fetch_state_e;

   // Opcode bit that marks a two-byte instruction.
   localparam int LONG_BIT = 7;

   // True in the states that drive a ROM read strobe.
   function automatic logic is_issue(input logic [2:0] st);
      return (st == ISSUE_OP) || (st == ISSUE_ARG);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface   : fetch_unit_if
//  Description : ROM read bus, jump redirect and instruction valid/ready
//                handshake of the fetch stage. master = fetch unit side,
//                slave = ROM / core side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
   parameter int size_addr = 8
) ();

   logic                 rom_read;
   logic [size_addr-1:0] rom_address;
   logic                 rom_ready;
   logic [7:0]           rom_data;

   logic                 jump;
   logic [size_addr-1:0] jump_addr;

   logic                 instr_valid;
   logic                 instr_ready;
   logic [7:0]           instr_opcode;
   logic [7:0]           instr_operand;
   logic                 instr_long;
   logic [size_addr-1:0] instr_pc;

   modport master (
      output rom_read, rom_address,
      input  rom_ready, rom_data,
      input  jump, jump_addr,
      output instr_valid, instr_opcode, instr_operand, instr_long, instr_pc,
      input  instr_ready
   );

   modport slave (
      input  rom_read, rom_address,
      output rom_ready, rom_data,
      output jump, jump_addr,
      input  instr_valid, instr_opcode, instr_operand, instr_long, instr_pc,
      output instr_ready
   );

endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Walks the PC through the program
//                ROM one byte at a time (single read in flight), assembles
//                one- or two-byte instructions and offers them to the core on
//                a valid/ready handshake. Jumps redirect at any time.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
   import lite_fetch_pkg::*;
#(
   parameter int          size_addr = 8,
   parameter int unsigned reset_pc  = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);

   localparam logic [2:0] ST_IDLE      = IDLE;
   localparam logic [2:0] ST_ISSUE_OP  = ISSUE_OP;
   localparam logic [2:0] ST_WAIT_OP   = WAIT_OP;
   localparam logic [2:0] ST_ISSUE_ARG = ISSUE_ARG;
   localparam logic [2:0] ST_WAIT_ARG  = WAIT_ARG;
   localparam logic [2:0] ST_HOLD      = HOLD;
   localparam logic [2:0] ST_SQUASH    = SQUASH;

   localparam logic [size_addr-1:0] PC_INIT = size_addr'(reset_pc);
   localparam logic [size_addr-1:0] PC_STEP = size_addr'(1);

   logic [2:0]           state;
   logic [2:0]           state_nxt;
   logic [size_addr-1:0] pc;
   logic [7:0]           opcode;
   logic [7:0]           operand;
   logic                 is_long;
   logic [size_addr-1:0] op_pc;

   logic jump_taken;
   logic op_done;
   logic arg_done;

   // A jump is ignored only in IDLE; a returning byte is consumed only in a
   // WAIT state and only when no jump overrides it in the same cycle.
   assign jump_taken = bus.jump && (state != ST_IDLE);
   assign op_done    = (state == ST_WAIT_OP)  && bus.rom_ready && !jump_taken;
   assign arg_done   = (state == ST_WAIT_ARG) && bus.rom_ready && !jump_taken;

   // Next-state selection; a jump overrides every other transition.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:      state_nxt = ST_ISSUE_OP;
         ST_ISSUE_OP:  state_nxt = ST_WAIT_OP;
         ST_WAIT_OP: begin
            if (bus.rom_ready) begin
               state_nxt = bus.rom_data[LONG_BIT] ? ST_ISSUE_ARG : ST_HOLD;
            end
         end
         ST_ISSUE_ARG: state_nxt = ST_WAIT_ARG;
         ST_WAIT_ARG: begin
            if (bus.rom_ready) begin
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.instr_ready) begin
               state_nxt = ST_ISSUE_OP;
            end
         end
         ST_SQUASH:    state_nxt = ST_ISSUE_OP;
         default:      state_nxt = ST_IDLE;
      endcase
      // A read issued in the jump cycle is still in flight, so it is
      // drained through SQUASH; otherwise the redirect fetch starts at once.
      if (jump_taken) begin
         state_nxt = is_issue(state) ? ST_SQUASH : ST_ISSUE_OP;
      end
   end

   // State, PC and instruction registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         pc      <= PC_INIT;
         opcode  <= 8'h00;
         operand <= 8'h00;
         is_long <= 1'b0;
         op_pc   <= '0;
      end else begin
         state <= state_nxt;
         if (jump_taken) begin
            pc <= bus.jump_addr;
         end else if (op_done) begin
            opcode  <= bus.rom_data;
            is_long <= bus.rom_data[LONG_BIT];
            op_pc   <= pc;
            pc      <= pc + PC_STEP;
            if (!bus.rom_data[LONG_BIT]) begin
               operand <= 8'h00;
            end
         end else if (arg_done) begin
            operand <= bus.rom_data;
            pc      <= pc + PC_STEP;
         end
      end
   end

   // Moore outputs, decoded from state and registers only.
   assign bus.rom_read      = is_issue(state);
   assign bus.rom_address   = pc;
   assign bus.instr_valid   = (state == ST_HOLD);
   assign bus.instr_opcode  = opcode;
   assign bus.instr_operand = operand;
   assign bus.instr_long    = is_long;
   assign bus.instr_pc      = op_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A ROM model answers
//                each read one cycle later; a reference model tracks the
//                architectural PC and decodes the expected instruction
//                straight from the ROM image at every handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
   import lite_fetch_pkg::*;

   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   fetch_unit_if #(.size_addr(AW)) bus ();

   fetch_unit #(.size_addr(AW), .reset_pc(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0]  rom [256];
   int          n_checks = 0;
   int          n_errors = 0;

   // reference model state
   logic [7:0]  exp_pc;
   int          nread;
   logic        pend_read;
   logic [7:0]  pend_data;
   int          cyc = 0;
   int          rel_cyc;
   int          ndeliv = 0;
   int          hs_cyc;
   int          stall;
   logic        hold_prev;
   logic [25:0] snap;

   // observations of the most recent cycle
   logic        last_read, last_valid;
   logic [7:0]  last_addr;
   logic [7:0]  d_op, d_arg, d_pc;
   logic        d_long;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [25:0] outs();
      return {bus.instr_valid, bus.instr_opcode, bus.instr_operand, bus.instr_long, bus.instr_pc};
   endfunction

   task automatic model_reset();
      exp_pc          = 8'h00;
      nread           = 0;
      pend_read       = 1'b0;
      pend_data       = 8'h00;
      hold_prev       = 1'b0;
      stall           = 0;
      bus.rom_ready   = 1'b0;
      bus.rom_data    = 8'h00;
      bus.jump        = 1'b0;
      bus.jump_addr   = 8'h00;
      bus.instr_ready = 1'b0;
   endtask

   // One clock cycle: observe outputs at the negedge, answer the ROM, drive
   // the core inputs for the coming edge and advance the reference model.
   task automatic cycle(input logic rdy, input logic jmp, input logic [7:0] ja);
      logic [7:0] op;
      logic       lng;
      @(negedge clk);
      cyc++;
      last_read  = bus.rom_read;
      last_valid = bus.instr_valid;
      last_addr  = bus.rom_address;
      if (hold_prev) check("hold_stable", outs(), snap);
      if (bus.rom_read) begin
         check("read_while_valid", bus.instr_valid, 0);
         check("read_addr", bus.rom_address, 8'(exp_pc + 8'(nread)));
         if (nread != 0) check("arg_read_legal", (nread == 1) && rom[exp_pc][7], 1);
         nread++;
      end
      bus.rom_ready = pend_read;
      bus.rom_data  = pend_read ? pend_data : 8'($urandom);
      pend_read     = bus.rom_read;
      pend_data     = rom[bus.rom_address];
      bus.instr_ready = rdy;
      bus.jump        = jmp;
      bus.jump_addr   = ja;
      hold_prev = bus.instr_valid && !rdy && !jmp;
      snap      = outs();
      if (bus.instr_valid || jmp) stall = 0; else stall++;
      check("fetch_stall", stall > 9, 0);
      if (jmp) begin
         exp_pc = ja;
         nread  = 0;
      end else if (bus.instr_valid && rdy) begin
         op  = rom[exp_pc];
         lng = op[7];
         check("opcode",     bus.instr_opcode, op);
         check("long",       bus.instr_long, lng);
         check("operand",    bus.instr_operand, lng ? rom[8'(exp_pc + 8'd1)] : 8'h00);
         check("instr_pc",   bus.instr_pc, exp_pc);
         check("bytes_read", nread, lng ? 2 : 1);
         d_op = bus.instr_opcode; d_arg = bus.instr_operand;
         d_long = bus.instr_long; d_pc = bus.instr_pc;
         hs_cyc = cyc;
         ndeliv++;
         exp_pc = 8'(exp_pc + (lng ? 8'd2 : 8'd1));
         nread  = 0;
      end
   endtask

   task automatic run_until_read(input logic rdy);
      int n;
      for (n = 0; n < 30; n++) begin
         cycle(rdy, 1'b0, 8'h00);
         if (last_read) break;
      end
      check("read_wait", n < 30, 1);
   endtask

   task automatic run_until_deliv();
      int n;
      int nd;
      nd = ndeliv;
      for (n = 0; n < 30; n++) begin
         cycle(1'b1, 1'b0, 8'h00);
         if (ndeliv != nd) break;
      end
      check("deliv_wait", n < 30, 1);
   endtask

   task automatic run_until_valid();
      int n;
      for (n = 0; n < 30; n++) begin
         cycle(1'b0, 1'b0, 8'h00);
         if (last_valid) break;
      end
      check("valid_wait", n < 30, 1);
   endtask

   initial begin
      int rd_cyc;
      int nd;
      int prev_hs;
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      rom[0] = 8'h05; rom[1] = 8'h83; rom[2] = 8'h2A; rom[3] = 8'h01;
      rom[4] = 8'h83; rom[5] = 8'h2A;
      rom[6] = 8'h8C; rom[7] = 8'h11;
      rom[8'h40] = 8'h22; rom[8'h41] = 8'h85;
      rom[8'h10] = 8'h8F; rom[8'h11] = 8'h3C; rom[8'h12] = 8'h07;
      rom[8'h20] = 8'h09; rom[8'h21] = 8'h04;

      // reset values
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_rom_read", bus.rom_read, 0);
      check("rst_valid",    bus.instr_valid, 0);
      check("rst_long",     bus.instr_long, 0);
      check("rst_opcode",   bus.instr_opcode, 0);
      check("rst_operand",  bus.instr_operand, 0);
      check("rst_pc",       bus.instr_pc, 0);
      check("rst_address",  bus.rom_address, 0);

      // basic stream 05 / 83 2A / 01; the release cycle is cycle 1 (IDLE),
      // so the first read shows up one observation later
      @(negedge clk);
      rst_n   = 1'b1;
      rel_cyc = cyc;
      run_until_read(1'b1);
      rd_cyc = cyc;
      check("first_read_cycle", rd_cyc - rel_cyc, 1);
      run_until_deliv();
      check("i0_op", d_op, 8'h05); check("i0_long", d_long, 0); check("i0_pc", d_pc, 0);
      check("i0_latency", hs_cyc - rd_cyc, 2);
      prev_hs = hs_cyc;
      run_until_deliv();
      check("i1_op", d_op, 8'h83); check("i1_arg", d_arg, 8'h2A);
      check("i1_long", d_long, 1); check("i1_pc", d_pc, 1);
      check("i1_interval", hs_cyc - prev_hs, 5);
      prev_hs = hs_cyc;
      run_until_deliv();
      check("i2_op", d_op, 8'h01); check("i2_arg", d_arg, 8'h00); check("i2_pc", d_pc, 3);
      check("i2_interval", hs_cyc - prev_hs, 3);

      // backpressure on {83, 2A} at address 4
      run_until_valid();
      repeat (10) cycle(1'b0, 1'b0, 8'h00);
      check("bp_valid", bus.instr_valid, 1);
      check("bp_op", bus.instr_opcode, 8'h83);
      check("bp_arg", bus.instr_operand, 8'h2A);
      check("bp_pc", bus.instr_pc, 4);
      cycle(1'b1, 1'b0, 8'h00);
      run_until_read(1'b1);
      check("bp_next_addr", last_addr, 8'h06);

      // jump to 0x40 while waiting for the operand byte
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 8'h00);
      check("wa_arg_read", {last_read, last_addr}, {1'b1, 8'h07});
      nd = ndeliv;
      cycle(1'b1, 1'b1, 8'h40);
      check("wa_no_read", last_read, 0);
      cycle(1'b1, 1'b0, 8'h00);
      check("wa_redirect", {last_read, last_addr}, {1'b1, 8'h40});
      check("wa_dropped", ndeliv, nd);
      run_until_deliv();
      check("wa_pc", d_pc, 8'h40); check("wa_op", d_op, 8'h22);

      // jump to 0x10 during an opcode issue goes through SQUASH
      cycle(1'b1, 1'b1, 8'h10);
      check("sq_issue", {last_read, last_addr}, {1'b1, 8'h41});
      cycle(1'b1, 1'b0, 8'h00);
      check("sq_squash", last_read, 0);
      cycle(1'b1, 1'b0, 8'h00);
      check("sq_redirect", {last_read, last_addr}, {1'b1, 8'h10});
      run_until_deliv();
      check("sq_pc", d_pc, 8'h10); check("sq_op", d_op, 8'h8F); check("sq_arg", d_arg, 8'h3C);

      // jump together with instr_ready in HOLD
      run_until_valid();
      nd = ndeliv;
      cycle(1'b1, 1'b1, 8'h20);
      check("hj_no_handshake", ndeliv, nd);
      cycle(1'b1, 1'b0, 8'h00);
      check("hj_redirect", {last_read, last_addr}, {1'b1, 8'h20});
      run_until_deliv();
      check("hj_pc", d_pc, 8'h20); check("hj_op", d_op, 8'h09);

      // operand straddling the address wrap
      rom[8'hFF] = 8'h90; rom[8'h00] = 8'h77;
      cycle(1'b1, 1'b1, 8'hFF);
      run_until_deliv();
      check("wr_pc", d_pc, 8'hFF); check("wr_op", d_op, 8'h90);
      check("wr_arg", d_arg, 8'h77); check("wr_long", d_long, 1);
      run_until_read(1'b1);
      check("wr_next_addr", last_addr, 8'h01);

      // asynchronous reset while waiting for the opcode byte
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_rom_read", bus.rom_read, 0);
      check("ar_valid",    bus.instr_valid, 0);
      check("ar_long",     bus.instr_long, 0);
      check("ar_opcode",   bus.instr_opcode, 0);
      check("ar_operand",  bus.instr_operand, 0);
      check("ar_pc",       bus.instr_pc, 0);
      check("ar_address",  bus.rom_address, 0);
      model_reset();
      rom[8'h00] = 8'h05;
      @(negedge clk);
      rst_n   = 1'b1;
      rel_cyc = cyc;
      run_until_read(1'b1);
      check("ar_first_read", {8'(cyc - rel_cyc), last_addr}, {8'd1, 8'h00});
      run_until_deliv();
      check("ar_restart_pc", d_pc, 8'h00); check("ar_restart_op", d_op, 8'h05);

      // randomized traffic on a fresh ROM image
      rst_n = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom % 4) != 0, ($urandom % 20) == 0, 8'($urandom));
      end
      check("random_delivered", ndeliv > 300, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
